// File: rtl/gb_irq_pkg.sv
// rtl/gb_irq_pkg.sv - shared constants, state type and vector helper for the irq controller
package gb_irq_pkg;

  localparam int IRQ_NSRC   = 5;
  localparam int IRQ_VBLANK = 0;
  localparam int IRQ_STAT   = 1;
  localparam int IRQ_TIMER  = 2;
  localparam int IRQ_SERIAL = 3;
  localparam int IRQ_JOYPAD = 4;

  localparam logic [7:0]  VEC_BASE_DEFAULT = 8'h40;
  localparam logic [15:0] ADDR_IF          = 16'hFF0F;
  localparam logic [15:0] ADDR_IE          = 16'hFFFF;

  typedef enum logic {
    IDLE     = 1'b0,
    DISPATCH = 1'b1
  } irq_state_t;

  // Vectors are spaced 8 bytes apart starting at base.
  function automatic logic [7:0] irq_vector(input logic [7:0] base, input logic [2:0] idx);
    return base + {2'b00, idx, 3'b000};
  endfunction

endpackage

// File: rtl/gb_irq_prio_enc.sv
// rtl/gb_irq_prio_enc.sv - lowest-index-wins priority encoder over pending sources
module gb_irq_prio_enc #(
  parameter int NSRC = 5
) (
  input  logic [NSRC-1:0] pend,
  output logic            valid,
  output logic [2:0]      idx
);

  // Scanning downward lets the lowest set index overwrite any higher one.
  always_comb begin
    valid = 1'b0;
    idx   = 3'd0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (pend[i]) begin
        valid = 1'b1;
        idx   = 3'(i);
      end
    end
  end

endmodule

// File: rtl/gb_irq_ctrl.sv
// rtl/gb_irq_ctrl.sv - IF/IE registers, priority select and two-step CPU dispatch handshake
// Build option GB_IRQ_EDGE_DETECT_EN: set IF on rising edges of irq_src instead of raw 1-ce pulses.
module gb_irq_ctrl
  import gb_irq_pkg::*;
#(
  parameter int         NSRC     = IRQ_NSRC,
  parameter logic [7:0] VEC_BASE = VEC_BASE_DEFAULT
) (
  input  logic            clk_sys,
  input  logic            reset,
  input  logic            ce,
  input  logic [NSRC-1:0] irq_src,
  input  logic            cpu_sel_if,
  input  logic            cpu_sel_ie,
  input  logic            cpu_wr,
  input  logic [7:0]      cpu_di,
  output logic [7:0]      cpu_do,
  output logic            int_req,
  output logic            halt_wake,
  input  logic            int_ack,
  input  logic            int_vec_rd,
  output logic [7:0]      int_vector
);

  irq_state_t      state_q, state_d;
  logic [NSRC-1:0] if_q;
  logic [7:0]      ie_q;
  logic [NSRC-1:0] evt;
  logic [NSRC-1:0] pend;
  logic [NSRC-1:0] clr_mask;
  logic            pend_valid;
  logic [2:0]      pend_idx;
  logic            vec_load;
  logic            wr_if, wr_ie;

  assign wr_if = ce & cpu_wr & cpu_sel_if;
  assign wr_ie = ce & cpu_wr & cpu_sel_ie;

`ifdef GB_IRQ_EDGE_DETECT_EN
  logic [NSRC-1:0] irq_src_q;

  always_ff @(posedge clk_sys) begin
    if (reset)   irq_src_q <= '0;
    else if (ce) irq_src_q <= irq_src;
  end

  // Level-held lines (STAT) raise IF only once per rising edge.
  assign evt = irq_src & ~irq_src_q;
`else
  assign evt = irq_src;
`endif

  assign pend      = if_q & ie_q[NSRC-1:0];
  assign halt_wake = |pend;

  gb_irq_prio_enc #(.NSRC(NSRC)) u_prio (
    .pend  (pend),
    .valid (pend_valid),
    .idx   (pend_idx)
  );

  // New events are OR-ed last so they survive a same-ce CPU write or dispatch clear.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      if_q <= '0;
      ie_q <= '0;
    end else if (ce) begin
      if_q <= (wr_if ? cpu_di[NSRC-1:0] : (if_q & ~clr_mask)) | evt;
      if (wr_ie) ie_q <= cpu_di;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset)         state_q <= IDLE;
    else               state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (ce && int_ack)    state_d = DISPATCH;
      DISPATCH: if (ce && int_vec_rd) state_d = IDLE;
      default:                        state_d = IDLE;
    endcase
  end

  // Pending is re-evaluated at the vector read, so a source disabled during the push cancels.
  always_comb begin
    int_req  = 1'b0;
    vec_load = 1'b0;
    clr_mask = '0;
    case (state_q)
      IDLE:     int_req = |pend;
      DISPATCH: begin
        vec_load = ce & int_vec_rd;
        if (vec_load && pend_valid) begin
          for (int i = 0; i < NSRC; i++) clr_mask[i] = (pend_idx == 3'(i));
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset)         int_vector <= 8'h00;
    else if (vec_load) int_vector <= pend_valid ? irq_vector(VEC_BASE, pend_idx) : 8'h00;
  end

  always_comb begin
    cpu_do = 8'hFF;
    if (cpu_sel_if)      cpu_do = {{(8 - NSRC){1'b1}}, if_q};
    else if (cpu_sel_ie) cpu_do = ie_q;
  end

endmodule

// File: tb/tb_gb_irq_ctrl.sv
// tb/tb_gb_irq_ctrl.sv - directed vector table plus hand sequences for gb_irq_ctrl
module tb_gb_irq_ctrl;

  logic       clk_sys = 1'b0;
  logic       reset;
  logic       ce;
  logic [4:0] irq_src;
  logic       cpu_sel_if, cpu_sel_ie, cpu_wr;
  logic [7:0] cpu_di, cpu_do;
  logic       int_req, halt_wake, int_ack, int_vec_rd;
  logic [7:0] int_vector;

  int checks = 0;
  int errors = 0;

  gb_irq_ctrl dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .ce         (ce),
    .irq_src    (irq_src),
    .cpu_sel_if (cpu_sel_if),
    .cpu_sel_ie (cpu_sel_ie),
    .cpu_wr     (cpu_wr),
    .cpu_di     (cpu_di),
    .cpu_do     (cpu_do),
    .int_req    (int_req),
    .halt_wake  (halt_wake),
    .int_ack    (int_ack),
    .int_vec_rd (int_vec_rd),
    .int_vector (int_vector)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic       ce;
    logic [4:0] src;
    logic       wif;
    logic       wie;
    logic [7:0] di;
    logic       ack;
    logic       vrd;
    logic [4:0] e_if;
    logic [7:0] e_ie;
    logic       e_req;
    logic       e_wake;
    logic [7:0] e_vec;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic c, logic [4:0] s, logic wif, logic wie, logic [7:0] d,
                              logic a, logic v, logic [4:0] eif, logic [7:0] eie,
                              logic rq, logic wk, logic [7:0] ev);
    vec_t r;
    r.ce = c; r.src = s; r.wif = wif; r.wie = wie; r.di = d; r.ack = a; r.vrd = v;
    r.e_if = eif; r.e_ie = eie; r.e_req = rq; r.e_wake = wk; r.e_vec = ev;
    return r;
  endfunction

  task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    ce = 1'b0; irq_src = '0; cpu_sel_if = 0; cpu_sel_ie = 0; cpu_wr = 0;
    cpu_di = '0; int_ack = 0; int_vec_rd = 0;
  endtask

  task automatic drive(input logic c, input logic [4:0] s, input logic wif, input logic wie,
                       input logic [7:0] d, input logic a, input logic v);
    @(negedge clk_sys);
    ce = c; irq_src = s; cpu_sel_if = wif; cpu_sel_ie = wie;
    cpu_wr = wif | wie; cpu_di = d; int_ack = a; int_vec_rd = v;
    @(posedge clk_sys);
    #1 idle_inputs();
  endtask

  task automatic check_state(input string tag, input logic [4:0] eif, input logic [7:0] eie,
                             input logic rq, input logic wk, input logic [7:0] ev);
    cpu_sel_if = 1'b1;
    #1 cmp({tag, " IF"}, cpu_do, {3'b111, eif});
    cpu_sel_if = 1'b0; cpu_sel_ie = 1'b1;
    #1 cmp({tag, " IE"}, cpu_do, eie);
    cpu_sel_ie = 1'b0;
    #1;
    cmp({tag, " int_req"}, {7'd0, int_req}, {7'd0, rq});
    cmp({tag, " halt_wake"}, {7'd0, halt_wake}, {7'd0, wk});
    cmp({tag, " int_vector"}, int_vector, ev);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not reach summary");
    $fatal(1);
  end

  initial begin
    logic [4:0] lvl_if;
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk_sys);
    @(negedge clk_sys);
    reset = 1'b0;
    #1;
    cmp("reset no-select read", cpu_do, 8'hFF);
    check_state("reset", 5'h00, 8'h00, 0, 0, 8'h00);

    //             ce src    wif wie di     ack vrd  IF     IE     req wake vec
    tbl.push_back(mk(1, 5'h00, 0, 1, 8'h04, 0, 0, 5'h00, 8'h04, 0, 0, 8'h00));
    tbl.push_back(mk(1, 5'h04, 0, 0, 8'h00, 0, 0, 5'h04, 8'h04, 1, 1, 8'h00));
    tbl.push_back(mk(1, 5'h00, 0, 0, 8'h00, 1, 0, 5'h04, 8'h04, 0, 1, 8'h00));
    tbl.push_back(mk(1, 5'h00, 0, 0, 8'h00, 1, 0, 5'h04, 8'h04, 0, 1, 8'h00));
    tbl.push_back(mk(1, 5'h00, 0, 0, 8'h00, 0, 1, 5'h00, 8'h04, 0, 0, 8'h50));
    tbl.push_back(mk(1, 5'h00, 0, 0, 8'h00, 0, 1, 5'h00, 8'h04, 0, 0, 8'h50));
    tbl.push_back(mk(1, 5'h00, 1, 0, 8'h1F, 0, 0, 5'h1F, 8'h04, 1, 1, 8'h50));
    tbl.push_back(mk(1, 5'h00, 0, 1, 8'h1F, 0, 0, 5'h1F, 8'h1F, 1, 1, 8'h50));
    tbl.push_back(mk(1, 5'h00, 0, 0, 8'h00, 1, 0, 5'h1F, 8'h1F, 0, 1, 8'h50));
    tbl.push_back(mk(1, 5'h00, 0, 0, 8'h00, 0, 1, 5'h1E, 8'h1F, 1, 1, 8'h40));
    tbl.push_back(mk(1, 5'h00, 0, 0, 8'h00, 1, 0, 5'h1E, 8'h1F, 0, 1, 8'h40));
    tbl.push_back(mk(1, 5'h00, 0, 0, 8'h00, 0, 1, 5'h1C, 8'h1F, 1, 1, 8'h48));
    tbl.push_back(mk(0, 5'h01, 1, 0, 8'h00, 1, 0, 5'h1C, 8'h1F, 1, 1, 8'h48));
    tbl.push_back(mk(1, 5'h08, 1, 0, 8'h00, 0, 0, 5'h08, 8'h1F, 1, 1, 8'h48));
    tbl.push_back(mk(1, 5'h00, 1, 0, 8'h00, 0, 0, 5'h00, 8'h1F, 0, 0, 8'h48));
    tbl.push_back(mk(1, 5'h04, 0, 0, 8'h00, 0, 0, 5'h04, 8'h1F, 1, 1, 8'h48));
    tbl.push_back(mk(1, 5'h00, 0, 0, 8'h00, 1, 0, 5'h04, 8'h1F, 0, 1, 8'h48));
    tbl.push_back(mk(1, 5'h04, 0, 0, 8'h00, 0, 1, 5'h04, 8'h1F, 1, 1, 8'h50));
    tbl.push_back(mk(1, 5'h00, 0, 0, 8'h00, 1, 0, 5'h04, 8'h1F, 0, 1, 8'h50));
    tbl.push_back(mk(1, 5'h00, 0, 0, 8'h00, 0, 1, 5'h00, 8'h1F, 0, 0, 8'h50));
    tbl.push_back(mk(1, 5'h00, 0, 1, 8'h01, 0, 0, 5'h00, 8'h01, 0, 0, 8'h50));
    tbl.push_back(mk(1, 5'h00, 1, 0, 8'h01, 0, 0, 5'h01, 8'h01, 1, 1, 8'h50));
    tbl.push_back(mk(1, 5'h00, 0, 0, 8'h00, 1, 0, 5'h01, 8'h01, 0, 1, 8'h50));
    tbl.push_back(mk(1, 5'h00, 0, 1, 8'h00, 0, 0, 5'h01, 8'h00, 0, 0, 8'h50));
    tbl.push_back(mk(1, 5'h00, 0, 0, 8'h00, 0, 1, 5'h01, 8'h00, 0, 0, 8'h00));
    tbl.push_back(mk(1, 5'h00, 0, 1, 8'h01, 0, 0, 5'h01, 8'h01, 1, 1, 8'h00));
    tbl.push_back(mk(1, 5'h00, 0, 0, 8'h00, 1, 1, 5'h01, 8'h01, 0, 1, 8'h00));
    tbl.push_back(mk(1, 5'h00, 0, 0, 8'h00, 0, 1, 5'h00, 8'h01, 0, 0, 8'h40));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].ce, tbl[i].src, tbl[i].wif, tbl[i].wie, tbl[i].di, tbl[i].ack, tbl[i].vrd);
      check_state($sformatf("vec%0d", i), tbl[i].e_if, tbl[i].e_ie, tbl[i].e_req,
                  tbl[i].e_wake, tbl[i].e_vec);
    end

    // Reset in the middle of a dispatch abandons it.
    drive(1, 5'h00, 1, 0, 8'h03, 0, 0);
    drive(1, 5'h00, 0, 0, 8'h00, 1, 0);
    check_state("pre-reset dispatch", 5'h03, 8'h01, 0, 1, 8'h40);
    @(negedge clk_sys);
    reset = 1'b1; ce = 1'b1;
    @(posedge clk_sys);
    #1 reset = 1'b0; ce = 1'b0;
    check_state("mid-dispatch reset", 5'h00, 8'h00, 0, 0, 8'h00);
    drive(1, 5'h00, 0, 1, 8'h01, 0, 0);
    drive(1, 5'h00, 1, 0, 8'h01, 0, 0);
    check_state("post-reset idle", 5'h01, 8'h01, 1, 1, 8'h00);
    drive(1, 5'h00, 0, 0, 8'h00, 0, 1);
    check_state("post-reset vec_rd ignored", 5'h01, 8'h01, 1, 1, 8'h00);

    // STAT line held high for 10 ce, IF cleared by the CPU during the hold.
    drive(1, 5'h00, 1, 0, 8'h00, 0, 0);
    drive(1, 5'h00, 0, 1, 8'h02, 0, 0);
    drive(1, 5'h02, 0, 0, 8'h00, 0, 0);
    check_state("stat first ce", 5'h02, 8'h02, 1, 1, 8'h00);
    drive(1, 5'h02, 1, 0, 8'h00, 0, 0);
`ifdef GB_IRQ_EDGE_DETECT_EN
    lvl_if = 5'h00;
`else
    lvl_if = 5'h02;
`endif
    for (int k = 0; k < 8; k++) drive(1, 5'h02, 0, 0, 8'h00, 0, 0);
    check_state("stat held", lvl_if, 8'h02, lvl_if[1], lvl_if[1], 8'h00);
    drive(1, 5'h00, 1, 0, 8'h00, 0, 0);
    check_state("stat fall", 5'h00, 8'h02, 0, 0, 8'h00);
    drive(1, 5'h02, 0, 0, 8'h00, 0, 0);
    check_state("stat re-rise", 5'h02, 8'h02, 1, 1, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
